ram_slice_reader: RTL and testbench

RAM_SLICE_READER -- requirements
Module: ram_slice_reader

---
 rtl/ram_slice_reader.sv | 198 +++++++++++++++++++
 tb/tb_ram_slice_reader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_slice_reader.sv
// Streams 40x48 RGB565 slices out of RAM as RGB888 pixels through a 2-entry FIFO.
// Define PIXEL_EXPAND_EN to fill the low colour bits by MSB replication instead of zeros.
module ram_slice_reader #(
  parameter int RAM_ADDR_WIDTH = 32,
  parameter int RAM_DATA_WIDTH = 16,
  parameter int IMAGE_IN_RAM   = 18
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      stream_ready,
  input  logic                      slice_req,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic                      ram_re,
  input  logic [RAM_DATA_WIDTH-1:0] ram_rdata,
  output logic [23:0]               pix_data,
  output logic                      pix_valid,
  input  logic                      pix_ready,
  output logic                      pix_last,
  output logic [7:0]                slice_idx,
  output logic                      slice_done
);

  localparam int IMAGE_SIZE = 40 * 48;
  localparam logic [10:0] LAST_PIX = 11'(IMAGE_SIZE - 1);
  localparam logic [7:0] LAST_SLICE = 8'(IMAGE_IN_RAM - 1);
  localparam logic [RAM_ADDR_WIDTH-1:0] ADDR_ONE = RAM_ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_REQ = 2'd1,
    READ     = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  function automatic logic [23:0] expand_px(input logic [15:0] px);
`ifdef PIXEL_EXPAND_EN
    expand_px = {px[15:11], px[15:13], px[10:5], px[10:9], px[4:0], px[4:2]};
`else
    expand_px = {px[15:11], 3'b000, px[10:5], 2'b00, px[4:0], 3'b000};
`endif
  endfunction

  state_t                    state_r;
  state_t                    state_next_s;
  logic [1:0]                occ_r;
  logic                      inflight_r;
  logic                      inflight_last_r;
  logic [10:0]               pix_cnt_r;
  logic [RAM_ADDR_WIDTH-1:0] addr_r;
  logic [7:0]                idx_r;
  logic                      done_r;
  logic [23:0]               head_data_r;
  logic                      head_last_r;
  logic [23:0]               tail_data_r;
  logic                      tail_last_r;
  logic                      pop_s;
  logic [2:0]                fill_s;
  logic                      last_read_s;
  logic                      finish_s;
  logic [23:0]               in_data_s;

  // Pop and projected fill; counting this cycle's pop lets reads sustain one pixel per cycle.
  always_comb begin
    pop_s       = (occ_r != 2'd0) && pix_ready;
    fill_s      = {1'b0, occ_r} - {2'b00, pop_s} + {2'b00, inflight_r};
    last_read_s = ram_re && (pix_cnt_r == LAST_PIX);
    finish_s    = (state_r == FLUSH) && (occ_r == 2'd0) && !inflight_r && stream_ready;
    in_data_s   = expand_px(ram_rdata[15:0]);
  end

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; a low stream_ready drops every state back to IDLE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (stream_ready) state_next_s = WAIT_REQ;
        else              state_next_s = IDLE;
      end
      WAIT_REQ: begin
        if (!stream_ready)  state_next_s = IDLE;
        else if (slice_req) state_next_s = READ;
        else                state_next_s = WAIT_REQ;
      end
      READ: begin
        if (!stream_ready)    state_next_s = IDLE;
        else if (last_read_s) state_next_s = FLUSH;
        else                  state_next_s = READ;
      end
      FLUSH: begin
        if (!stream_ready) state_next_s = IDLE;
        else if (finish_s) state_next_s = WAIT_REQ;
        else               state_next_s = FLUSH;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Output decode from state and FIFO occupancy.
  always_comb begin
    if ((state_r == READ) && (fill_s < 3'd2)) ram_re = 1'b1;
    else                                      ram_re = 1'b0;
    pix_valid = (occ_r != 2'd0);
    pix_last  = pix_valid && head_last_r;
  end

  assign ram_addr   = addr_r;
  assign pix_data   = head_data_r;
  assign slice_idx  = idx_r;
  assign slice_done = done_r;

  // Read issue, return capture, two-entry FIFO and slice bookkeeping.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      occ_r           <= 2'd0;
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
      pix_cnt_r       <= 11'd0;
      addr_r          <= '0;
      idx_r           <= 8'd0;
      done_r          <= 1'b0;
      head_data_r     <= 24'd0;
      head_last_r     <= 1'b0;
      tail_data_r     <= 24'd0;
      tail_last_r     <= 1'b0;
    end else if (!stream_ready) begin
      occ_r           <= 2'd0;
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
      pix_cnt_r       <= 11'd0;
      addr_r          <= '0;
      idx_r           <= 8'd0;
      done_r          <= 1'b0;
      head_last_r     <= 1'b0;
      tail_last_r     <= 1'b0;
    end else begin
      inflight_r      <= ram_re;
      inflight_last_r <= last_read_s;
      done_r          <= finish_s;
      if (ram_re) begin
        pix_cnt_r <= pix_cnt_r + 11'd1;
        addr_r    <= addr_r + ADDR_ONE;
      end else if (finish_s) begin
        pix_cnt_r <= 11'd0;
        if (idx_r == LAST_SLICE) begin
          idx_r  <= 8'd0;
          addr_r <= '0;
        end else begin
          idx_r <= idx_r + 8'd1;
        end
      end
      case ({inflight_r, pop_s})
        2'b10: begin
          if (occ_r == 2'd0) begin
            head_data_r <= in_data_s;
            head_last_r <= inflight_last_r;
            occ_r       <= 2'd1;
          end else begin
            tail_data_r <= in_data_s;
            tail_last_r <= inflight_last_r;
            occ_r       <= 2'd2;
          end
        end
        2'b01: begin
          if (occ_r == 2'd2) begin
            head_data_r <= tail_data_r;
            head_last_r <= tail_last_r;
            occ_r       <= 2'd1;
          end else begin
            head_last_r <= 1'b0;
            occ_r       <= 2'd0;
          end
        end
        2'b11: begin
          if (occ_r == 2'd2) begin
            head_data_r <= tail_data_r;
            head_last_r <= tail_last_r;
            tail_data_r <= in_data_s;
            tail_last_r <= inflight_last_r;
          end else begin
            head_data_r <= in_data_s;
            head_last_r <= inflight_last_r;
          end
        end
        default: occ_r <= occ_r;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_slice_reader.sv
// Randomised bench for ram_slice_reader: RAM model, per-slice pixel scoreboard, abort and reset cases.
module tb_ram_slice_reader;

  localparam int SLICE = 1920;
  localparam int NSL   = 18;
`ifdef PIXEL_EXPAND_EN
  localparam logic [23:0] EXP_WHITE = 24'hFFFFFF;
`else
  localparam logic [23:0] EXP_WHITE = 24'hF8FCF8;
`endif

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        stream_ready = 1'b0;
  logic        slice_req = 1'b0;
  logic        pix_ready = 1'b0;
  logic [15:0] ram_rdata = 16'd0;
  logic [31:0] ram_addr;
  logic        ram_re;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_last;
  logic [7:0]  slice_idx;
  logic        slice_done;

  always #5 clk = ~clk;

  ram_slice_reader dut (
    .clk(clk), .nrst(nrst), .stream_ready(stream_ready), .slice_req(slice_req),
    .ram_addr(ram_addr), .ram_re(ram_re), .ram_rdata(ram_rdata),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_last(pix_last),
    .slice_idx(slice_idx), .slice_done(slice_done)
  );

  logic [15:0] mem [0:NSL*SLICE-1];

  int checks = 0, errors = 0;
  int cyc = 0, slice_m = 0, xfer_k = 0, issue_k = 0, dones = 0, tail_wait = 0;
  int sr_hist = 0, req_cyc = 0, ready_mode = 0, rd_addr_pend = 0;
  bit reads_ok = 0, rd_pend = 0, prev_stall = 0, abort_chk = 0;
  bit sr_cmd = 0, req_cmd = 0, pin_first = 0, tput_chk = 0;
  logic [23:0] prev_data = 24'd0;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RGB565 -> RGB888 by scaling each channel arithmetically.
  function automatic int exp_px(input logic [15:0] d);
    int r, g, b, rr, gg, bb;
    r = int'(d) / 2048;
    g = (int'(d) / 32) % 64;
    b = int'(d) % 32;
    rr = r * 8;
    gg = g * 4;
    bb = b * 8;
`ifdef PIXEL_EXPAND_EN
    rr = rr + r / 4;
    gg = gg + g / 16;
    bb = bb + b / 4;
`endif
    return rr * 65536 + gg * 256 + bb;
  endfunction

  task automatic model_clear();
    slice_m = 0; xfer_k = 0; issue_k = 0; reads_ok = 0; tail_wait = 0;
  endtask

  task automatic tick();
    int a;
    bit xfer;
    @(negedge clk);
    cyc++;
    if (rd_pend) ram_rdata = mem[rd_addr_pend];
    else         ram_rdata = 16'($urandom);
    if (abort_chk) begin
      chk(pix_valid == 1'b0, "abort_valid", pix_valid, 0);
      chk(slice_done == 1'b0, "abort_done", slice_done, 0);
    end
    if (prev_stall) begin
      chk(pix_valid == 1'b1, "stall_valid", pix_valid, 1);
      chk(pix_data == prev_data, "stall_data", pix_data, prev_data);
    end
    if (slice_done) begin
      chk(xfer_k == SLICE, "done_count", xfer_k, SLICE);
      chk(slice_idx == 8'((slice_m + 1) % NSL), "idx_inc", slice_idx, (slice_m + 1) % NSL);
      dones++;
      if (dones == NSL) chk(slice_idx == 8'd0, "idx_wrap_lit", slice_idx, 0);
      if (tput_chk) begin
        chk((cyc - req_cyc) <= SLICE + 10, "throughput", cyc - req_cyc, SLICE + 10);
        tput_chk = 0;
      end
      slice_m = (slice_m + 1) % NSL; xfer_k = 0; issue_k = 0; reads_ok = 0; tail_wait = 0;
    end else begin
      chk(slice_idx == 8'(slice_m), "idx_hold", slice_idx, slice_m);
      if (xfer_k == SLICE) begin
        tail_wait++;
        chk(tail_wait < 8, "done_timeout", tail_wait, 8);
      end
    end
    stream_ready = sr_cmd;
    slice_req = req_cmd;
    req_cmd = 0;
    case (ready_mode)
      0:       pix_ready = 1'b1;
      1:       pix_ready = (cyc % 3 == 0);
      default: pix_ready = ($urandom_range(9, 0) != 0);
    endcase
    if (slice_req && stream_ready && sr_hist > 0 && issue_k == 0 && xfer_k == 0 && !reads_ok) begin
      reads_ok = 1;
      req_cyc = cyc;
    end
    #1;
    xfer = pix_valid && pix_ready;
    if (xfer) begin
      chk(xfer_k < issue_k, "xfer_unissued", xfer_k, issue_k);
      if (xfer_k < SLICE) begin
        a = slice_m * SLICE + xfer_k;
        chk(pix_data == 24'(exp_px(mem[a])), "pix_data", pix_data, exp_px(mem[a]));
        chk(pix_last == (xfer_k == SLICE - 1), "pix_last", pix_last, xfer_k == SLICE - 1);
        if (pin_first && xfer_k == 0) chk(pix_data == EXP_WHITE, "white_lit", pix_data, EXP_WHITE);
        if (pin_first && xfer_k == 1) chk(pix_data == 24'h000000, "black_lit", pix_data, 0);
      end
      xfer_k++;
    end
    if (ram_re) begin
      chk(reads_ok && issue_k < SLICE, "read_allowed", issue_k, SLICE);
      chk(ram_addr == 32'(slice_m * SLICE + issue_k), "ram_addr", ram_addr, slice_m * SLICE + issue_k);
      if (issue_k == 0 && slice_m == 17) chk(ram_addr == 32'd32640, "base17_lit", ram_addr, 32640);
      if (issue_k == 0 && dones >= NSL) chk(ram_addr == 32'd0, "restart_lit", ram_addr, 0);
      rd_pend = (ram_addr < 32'(NSL * SLICE));
      rd_addr_pend = rd_pend ? int'(ram_addr) : 0;
      issue_k++;
    end else begin
      rd_pend = 0;
    end
    chk((issue_k - xfer_k) <= 2, "outstanding", issue_k - xfer_k, 2);
    prev_stall = pix_valid && !pix_ready && stream_ready;
    prev_data = pix_data;
    abort_chk = !stream_ready;
    if (!stream_ready) begin
      model_clear();
      rd_pend = 0;
      sr_hist = 0;
    end else begin
      sr_hist++;
    end
  endtask

  task automatic run_until_xfer(input int target, input int budget);
    int n = 0;
    while (xfer_k < target && n < budget) begin
      if (issue_k == 200) req_cmd = 1;
      tick();
      n++;
    end
    chk(xfer_k >= target, "xfer_timeout", xfer_k, target);
  endtask

  initial begin
    int n;
    for (int i = 0; i < NSL * SLICE; i++) mem[i] = 16'($urandom);
    mem[0] = 16'hFFFF;
    mem[1] = 16'h0000;
    #1;
    chk(ram_re == 1'b0 && ram_addr == 32'd0, "rst_ram", ram_addr, 0);
    chk(pix_valid == 1'b0 && pix_last == 1'b0 && pix_data == 24'd0, "rst_pix", pix_data, 0);
    chk(slice_idx == 8'd0 && slice_done == 1'b0, "rst_slice", slice_idx, 0);
    repeat (3) tick();
    nrst = 1'b1;
    sr_cmd = 1;
    repeat (2) tick();

    for (int s = 0; s < NSL; s++) begin
      ready_mode = (s == 0) ? 0 : ((s < 3) ? 1 : 2);
      pin_first = (s == 0);
      tput_chk = (s == 0);
      req_cmd = 1;
      n = 0;
      while (dones < s + 1 && n < 8000) begin
        if (s == 4 && issue_k == 100) req_cmd = 1;
        tick();
        n++;
      end
      chk(dones == s + 1, "slice_timeout", dones, s + 1);
    end
    pin_first = 0;

    // Abort at pixel 500 of the slice after the wrap.
    ready_mode = 2;
    req_cmd = 1;
    run_until_xfer(500, 4000);
    sr_cmd = 0;
    repeat (4) tick();
    sr_cmd = 1;
    repeat (2) tick();

    // Reset mid-slice with a stray request during READ.
    req_cmd = 1;
    run_until_xfer(300, 4000);
    nrst = 1'b0;
    prev_stall = 0;
    #1;
    chk(ram_re == 1'b0 && ram_addr == 32'd0, "midrst_ram", ram_addr, 0);
    chk(pix_valid == 1'b0 && pix_last == 1'b0 && pix_data == 24'd0, "midrst_pix", pix_data, 0);
    chk(slice_idx == 8'd0 && slice_done == 1'b0, "midrst_slice", slice_idx, 0);
    sr_cmd = 0;
    repeat (3) tick();
    nrst = 1'b1;
    sr_cmd = 1;
    repeat (2) tick();
    req_cmd = 1;
    n = dones;
    run_until_xfer(SLICE, 6000);
    repeat (10) tick();
    chk(dones == n + 1, "final_done", dones, n + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
